// File: rtl/vlsu_meta_dispatcher.sv
// Meta-information FIFO that broadcasts each head entry to a per-entry subset of channels,
// with store-ordering fences gated by an outstanding AW-to-B counter.
module vlsu_meta_dispatcher #(
    parameter int unsigned Depth          = 4,
    parameter int unsigned NrChannels     = 2,
    parameter int unsigned MetaWidth      = 64,
    parameter int unsigned MaxOutstanding = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         enq_valid_i,
    output logic                         enq_ready_o,
    input  logic [MetaWidth-1:0]         enq_data_i,
    input  logic [NrChannels-1:0]        enq_mask_i,
    input  logic                         enq_fence_i,
    output logic [NrChannels-1:0]        deq_valid_o,
    input  logic [NrChannels-1:0]        deq_ready_i,
    output logic [MetaWidth-1:0]         deq_data_o,
    input  logic                         aw_fire_i,
    output logic                         aw_allow_o,
    input  logic                         b_valid_i,
    output logic                         b_ready_o,
    output logic                         st_pending_o,
    output logic [$clog2(Depth+1)-1:0]   usage_o,
    output logic                         err_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

    logic [MetaWidth-1:0]  data_q [Depth];
    logic [NrChannels-1:0] mask_q [Depth];
    logic [Depth-1:0]      fence_q;

    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [NrChannels-1:0] done_q, done_d;
    logic [OutW-1:0]       outst_q, outst_d;
    logic                  err_q, err_d;

    logic                  empty, head_go, push, pop;
    logic [NrChannels-1:0] head_mask, fire;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count_q == '0);
    assign head_mask = mask_q[rd_ptr_q];
    // Fence is gated by the registered counter, so release lags the last B by one cycle.
    assign head_go   = !empty && !(fence_q[rd_ptr_q] && (outst_q != '0));

    for (genvar gi = 0; gi < NrChannels; gi++) begin : g_chan
        assign deq_valid_o[gi] = head_go && head_mask[gi] && !done_q[gi];
        assign fire[gi]        = deq_valid_o[gi] && deq_ready_i[gi];
    end

    assign pop          = head_go && (&(~head_mask | done_q | fire));
    assign push         = enq_valid_i && enq_ready_o;
    assign enq_ready_o  = (count_q < CntW'(Depth));
    assign deq_data_o   = empty ? '0 : data_q[rd_ptr_q];
    assign aw_allow_o   = (outst_q < OutW'(MaxOutstanding));
    assign b_ready_o    = 1'b1;
    assign st_pending_o = (outst_q != '0);
    assign usage_o      = count_q;
    assign err_o        = err_q;

    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            data_q[wr_ptr_q]  <= enq_data_i;
            mask_q[wr_ptr_q]  <= enq_mask_i;
            fence_q[wr_ptr_q] <= enq_fence_i;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        done_d   = done_q;
        outst_d  = outst_q;
        err_d    = err_q;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            done_d   = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                done_d   = '0;
            end else begin
                done_d = done_q | fire;
            end
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (!push && pop) count_d = count_q - 1'b1;
        end

        // A same-cycle AW and B cancel out, even at the saturation limits.
        if (aw_fire_i && !b_valid_i) begin
            if (outst_q == OutW'(MaxOutstanding)) err_d = 1'b1;
            else                                  outst_d = outst_q + 1'b1;
        end else if (b_valid_i && !aw_fire_i) begin
            if (outst_q == '0) err_d = 1'b1;
            else               outst_d = outst_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            done_q   <= '0;
            outst_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
            outst_q  <= outst_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_vlsu_meta_dispatcher.sv
// Directed scenarios plus a randomized run checked against a queue-based reference model.
module tb_vlsu_meta_dispatcher;

    localparam int D  = 4;
    localparam int NC = 2;
    localparam int MW = 64;
    localparam int MO = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          enq_valid_i;
    logic          enq_ready_o;
    logic [MW-1:0] enq_data_i;
    logic [NC-1:0] enq_mask_i;
    logic          enq_fence_i;
    logic [NC-1:0] deq_valid_o;
    logic [NC-1:0] deq_ready_i;
    logic [MW-1:0] deq_data_o;
    logic          aw_fire_i;
    logic          aw_allow_o;
    logic          b_valid_i;
    logic          b_ready_o;
    logic          st_pending_o;
    logic [2:0]    usage_o;
    logic          err_o;

    int passed = 0;
    int total  = 0;

    always #5 clk_i = ~clk_i;

    vlsu_meta_dispatcher #(
        .Depth(D), .NrChannels(NC), .MetaWidth(MW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o), .enq_data_i(enq_data_i),
        .enq_mask_i(enq_mask_i), .enq_fence_i(enq_fence_i),
        .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i), .deq_data_o(deq_data_o),
        .aw_fire_i(aw_fire_i), .aw_allow_o(aw_allow_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .st_pending_o(st_pending_o), .usage_o(usage_o), .err_o(err_o)
    );

    typedef struct packed {
        logic [MW-1:0] data;
        logic [NC-1:0] mask;
        logic          fence;
    } ent_t;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs;
        flush_i     = 1'b0;
        enq_valid_i = 1'b0;
        enq_data_i  = '0;
        enq_mask_i  = '0;
        enq_fence_i = 1'b0;
        deq_ready_i = '0;
        aw_fire_i   = 1'b0;
        b_valid_i   = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset;
        logic [75:0] obs, expv;
        idle_inputs();
        rst_ni = 1'b0;
        #3;
        obs  = {enq_ready_o, deq_valid_o, deq_data_o, aw_allow_o, b_ready_o, st_pending_o, usage_o, err_o};
        expv = {1'b1, 2'b00, 64'h0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0};
        total++;
        if (obs !== expv) $display("FAIL reset_values: got %h expected %h", obs, expv);
        else passed++;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_fill_wrap;
        for (int i = 0; i < 5; i++) begin
            enq_valid_i = 1'b1;
            enq_data_i  = MW'(100 + i);
            enq_mask_i  = 2'b11;
            @(negedge clk_i);
            total++;
            if (enq_ready_o !== (i < 4)) $display("FAIL fill_enq_ready[%0d]: got %b expected %b", i, enq_ready_o, (i < 4));
            else passed++;
            if (i == 0) begin
                total++;
                if (deq_valid_o !== 2'b00) $display("FAIL no_bypass: got %b expected 00", deq_valid_o);
                else passed++;
            end
            tick();
        end
        idle_inputs();
        @(negedge clk_i);
        total++;
        if (usage_o !== 3'd4) $display("FAIL fill_usage: got %0d expected 4", usage_o);
        else passed++;
        tick();
        deq_ready_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            total++;
            if (deq_data_o !== MW'(100 + i) || deq_valid_o !== 2'b11)
                $display("FAIL drain_order[%0d]: got data %0d valid %b expected data %0d valid 11", i, deq_data_o, deq_valid_o, 100 + i);
            else passed++;
            tick();
        end
        enq_valid_i = 1'b1;
        enq_data_i  = MW'(200);
        enq_mask_i  = 2'b11;
        @(negedge clk_i);
        total++;
        if (deq_valid_o !== 2'b00 || usage_o !== 3'd0) $display("FAIL drained_empty: got valid %b usage %0d expected 00 0", deq_valid_o, usage_o);
        else passed++;
        tick();
        enq_valid_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (deq_data_o !== MW'(200) || deq_valid_o !== 2'b11) $display("FAIL wrap_entry: got data %0d valid %b expected 200 11", deq_data_o, deq_valid_o);
        else passed++;
        tick();
        idle_inputs();
    endtask

    task automatic test_split_ready;
        logic [NC-1:0] exp_v [4];
        logic [NC-1:0] rdy [4];
        exp_v = '{2'b11, 2'b10, 2'b10, 2'b10};
        rdy   = '{2'b01, 2'b00, 2'b00, 2'b10};
        enq_valid_i = 1'b1;
        enq_data_i  = MW'(64'hABCD);
        enq_mask_i  = 2'b11;
        tick();
        enq_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            deq_ready_i = rdy[k];
            @(negedge clk_i);
            total++;
            if (deq_valid_o !== exp_v[k] || usage_o !== 3'd1) $display("FAIL split_cycle%0d: got valid %b usage %0d expected %b 1", k, deq_valid_o, usage_o, exp_v[k]);
            else passed++;
            tick();
        end
        deq_ready_i = '0;
        @(negedge clk_i);
        total++;
        if (deq_valid_o !== 2'b00 || usage_o !== 3'd0) $display("FAIL split_pop: got valid %b usage %0d expected 00 0", deq_valid_o, usage_o);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_fence;
        aw_fire_i = 1'b1;
        repeat (3) tick();
        aw_fire_i   = 1'b0;
        enq_valid_i = 1'b1;
        enq_mask_i  = 2'b01;
        enq_fence_i = 1'b1;
        enq_data_i  = MW'(64'hFE);
        tick();
        idle_inputs();
        deq_ready_i = 2'b01;
        for (int k = 0; k < 3; k++) begin
            b_valid_i = 1'b1;
            @(negedge clk_i);
            total++;
            if (deq_valid_o !== 2'b00 || st_pending_o !== 1'b1) $display("FAIL fence_hold[%0d]: got valid %b pend %b expected 00 1", k, deq_valid_o, st_pending_o);
            else passed++;
            tick();
        end
        b_valid_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (deq_valid_o !== 2'b01 || st_pending_o !== 1'b0) $display("FAIL fence_release: got valid %b pend %b expected 01 0", deq_valid_o, st_pending_o);
        else passed++;
        tick();
        idle_inputs();
        @(negedge clk_i);
        total++;
        if (usage_o !== 3'd0) $display("FAIL fence_pop: got usage %0d expected 0", usage_o);
        else passed++;
    endtask

    task automatic test_outstanding_sat;
        do_reset();
        for (int k = 0; k < MO; k++) begin
            aw_fire_i = 1'b1;
            @(negedge clk_i);
            total++;
            if (aw_allow_o !== 1'b1) $display("FAIL aw_allow_before[%0d]: got %b expected 1", k, aw_allow_o);
            else passed++;
            tick();
        end
        aw_fire_i = 1'b1;
        b_valid_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (aw_allow_o !== 1'b0) $display("FAIL aw_allow_full: got %b expected 0", aw_allow_o);
        else passed++;
        tick();
        b_valid_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (aw_allow_o !== 1'b0 || err_o !== 1'b0) $display("FAIL aw_b_same_cycle: got allow %b err %b expected 0 0", aw_allow_o, err_o);
        else passed++;
        tick();
        aw_fire_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (err_o !== 1'b1 || aw_allow_o !== 1'b0) $display("FAIL aw_overflow_err: got err %b allow %b expected 1 0", err_o, aw_allow_o);
        else passed++;
        b_valid_i = 1'b1;
        repeat (MO) tick();
        b_valid_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (st_pending_o !== 1'b0 || aw_allow_o !== 1'b1 || err_o !== 1'b1) $display("FAIL drain_outstanding: got pend %b allow %b err %b expected 0 1 1", st_pending_o, aw_allow_o, err_o);
        else passed++;
        tick();
    endtask

    task automatic test_underflow_mask0;
        do_reset();
        b_valid_i = 1'b1;
        tick();
        b_valid_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (err_o !== 1'b1 || st_pending_o !== 1'b0 || aw_allow_o !== 1'b1) $display("FAIL b_underflow: got err %b pend %b allow %b expected 1 0 1", err_o, st_pending_o, aw_allow_o);
        else passed++;
        enq_valid_i = 1'b1;
        enq_mask_i  = 2'b00;
        enq_data_i  = MW'(64'h55);
        tick();
        idle_inputs();
        deq_ready_i = 2'b11;
        @(negedge clk_i);
        total++;
        if (deq_valid_o !== 2'b00 || usage_o !== 3'd1) $display("FAIL mask0_head: got valid %b usage %0d expected 00 1", deq_valid_o, usage_o);
        else passed++;
        tick();
        @(negedge clk_i);
        total++;
        if (usage_o !== 3'd0 || deq_valid_o !== 2'b00) $display("FAIL mask0_pop: got usage %0d valid %b expected 0 00", usage_o, deq_valid_o);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_flush;
        do_reset();
        aw_fire_i = 1'b1;
        repeat (2) tick();
        aw_fire_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enq_valid_i = 1'b1;
            enq_mask_i  = 2'b11;
            enq_data_i  = MW'(300 + i);
            tick();
        end
        enq_valid_i = 1'b0;
        deq_ready_i = 2'b01;
        @(negedge clk_i);
        total++;
        if (deq_valid_o !== 2'b11 || usage_o !== 3'd3) $display("FAIL pre_flush: got valid %b usage %0d expected 11 3", deq_valid_o, usage_o);
        else passed++;
        tick();
        deq_ready_i = 2'b00;
        @(negedge clk_i);
        total++;
        if (deq_valid_o !== 2'b10) $display("FAIL ch0_done: got valid %b expected 10", deq_valid_o);
        else passed++;
        tick();
        flush_i     = 1'b1;
        enq_valid_i = 1'b1;
        enq_mask_i  = 2'b11;
        deq_ready_i = 2'b11;
        tick();
        idle_inputs();
        @(negedge clk_i);
        total++;
        if (usage_o !== 3'd0 || deq_valid_o !== 2'b00 || deq_data_o !== '0 || st_pending_o !== 1'b1 || enq_ready_o !== 1'b1)
            $display("FAIL flush_result: got usage %0d valid %b data %h pend %b rdy %b expected 0 00 0 1 1", usage_o, deq_valid_o, deq_data_o, st_pending_o, enq_ready_o);
        else passed++;
        tick();
    endtask

    task automatic test_async_reset;
        logic [75:0] obs, expv;
        aw_fire_i = 1'b1;
        b_valid_i = 1'b0;
        enq_valid_i = 1'b1;
        enq_mask_i  = 2'b11;
        enq_data_i  = MW'(64'h777);
        repeat (2) tick();
        b_valid_i = 1'b1;
        aw_fire_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (usage_o === 3'd0 || st_pending_o !== 1'b1) $display("FAIL pre_async: got usage %0d pend %b expected nonzero 1", usage_o, st_pending_o);
        else passed++;
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        obs  = {enq_ready_o, deq_valid_o, deq_data_o, aw_allow_o, b_ready_o, st_pending_o, usage_o, err_o};
        expv = {1'b1, 2'b00, 64'h0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0};
        total++;
        if (obs !== expv) $display("FAIL async_reset: got %h expected %h", obs, expv);
        else passed++;
        idle_inputs();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_random;
        ent_t          q[$];
        ent_t          e;
        logic [NC-1:0] m_done, fire, ev;
        int            outs;
        logic          m_err, hg, er, popc;
        logic [75:0]   obs, expv;
        logic [MW-1:0] ed;
        do_reset();
        outs   = 0;
        m_err  = 1'b0;
        m_done = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            flush_i     = ($urandom_range(0, 31) == 0);
            enq_valid_i = $urandom_range(0, 1) == 1;
            enq_data_i  = {$urandom, $urandom};
            enq_mask_i  = NC'($urandom_range(0, 3));
            enq_fence_i = ($urandom_range(0, 7) == 0);
            deq_ready_i = NC'($urandom_range(0, 3));
            aw_fire_i   = ($urandom_range(0, 3) == 0);
            b_valid_i   = ($urandom_range(0, 2) == 0);

            er = (q.size() < D);
            hg = (q.size() > 0) && !(q[0].fence && outs != 0);
            ev = '0;
            ed = '0;
            if (q.size() > 0) begin
                ed = q[0].data;
                if (hg) ev = q[0].mask & ~m_done;
            end
            @(negedge clk_i);
            obs  = {enq_ready_o, deq_valid_o, deq_data_o, aw_allow_o, b_ready_o, st_pending_o, usage_o, err_o};
            expv = {er, ev, ed, (outs < MO), 1'b1, (outs != 0), 3'(q.size()), m_err};
            total++;
            if (obs !== expv) $display("FAIL random_cycle%0d: got %h expected %h", cyc, obs, expv);
            else passed++;

            if (flush_i) begin
                q.delete();
                m_done = '0;
            end else begin
                fire = ev & deq_ready_i;
                popc = hg && ((q[0].mask & ~(m_done | fire)) == '0);
                if (popc) begin
                    void'(q.pop_front());
                    m_done = '0;
                end else begin
                    m_done = m_done | fire;
                end
                if (enq_valid_i && er) begin
                    e.data  = enq_data_i;
                    e.mask  = enq_mask_i;
                    e.fence = enq_fence_i;
                    q.push_back(e);
                end
            end
            if (aw_fire_i && !b_valid_i) begin
                if (outs == MO) m_err = 1'b1;
                else outs++;
            end else if (b_valid_i && !aw_fire_i) begin
                if (outs == 0) m_err = 1'b1;
                else outs--;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill_wrap();
        test_split_ready();
        test_fence();
        test_outstanding_sat();
        test_underflow_mask0();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
